// File: rtl/raster_pkg.sv
// Shared types and screen defaults for the span scheduling path.
package raster_pkg;

  localparam int DEFAULT_SCREEN_W = 640;
  localparam int DEFAULT_SCREEN_H = 480;

  typedef struct packed {
    logic [15:0] x0;
    logic [15:0] x1;
    logic [15:0] y;
    logic [15:0] z1;
    logic [15:0] z2;
  } span_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_WAIT  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/span_normalize.sv
// Orders span endpoints (z follows x), culls off-screen spans and clamps x1.
module span_normalize
  import raster_pkg::*;
#(
  parameter int SCREEN_W = DEFAULT_SCREEN_W,
  parameter int SCREEN_H = DEFAULT_SCREEN_H
) (
  input  span_t span_in,
  output span_t span_out,
  output logic  cull
);

  localparam logic [15:0] W_LIM = 16'(SCREEN_W);
  localparam logic [15:0] H_LIM = 16'(SCREEN_H);
  localparam logic [15:0] X_MAX = 16'(SCREEN_W - 1);

  span_t ord_s;

  // Swap endpoints when reversed, then decide cull and clamp the right edge.
  always_comb begin
    ord_s = span_in;
    if (span_in.x0 > span_in.x1) begin
      ord_s.x0 = span_in.x1;
      ord_s.x1 = span_in.x0;
      ord_s.z1 = span_in.z2;
      ord_s.z2 = span_in.z1;
    end else begin
      ord_s = span_in;
    end
    cull     = (ord_s.y >= H_LIM) || (ord_s.x0 >= W_LIM);
    span_out = ord_s;
    if (ord_s.x1 > X_MAX) begin
      span_out.x1 = X_MAX;
    end else begin
      span_out.x1 = ord_s.x1;
    end
  end

endmodule

// File: rtl/span_scheduler.sv
// Round-robin arbiter feeding normalized spans to the shared span engine.
module span_scheduler
  import raster_pkg::*;
#(
  parameter int SCREEN_W = DEFAULT_SCREEN_W,
  parameter int SCREEN_H = DEFAULT_SCREEN_H
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0][15:0] req_x0,
  input  logic [1:0][15:0] req_x1,
  input  logic [1:0][15:0] req_y,
  input  logic [1:0][15:0] req_z1,
  input  logic [1:0][15:0] req_z2,
  output logic             eng_start,
  output logic [15:0]      eng_x0,
  output logic [15:0]      eng_y0,
  output logic [15:0]      eng_x1,
  output logic [15:0]      eng_y1,
  output logic [15:0]      eng_z1,
  output logic [15:0]      eng_z2,
  input  logic             eng_done,
  output logic             busy,
  output logic             grant_id,
  output logic [15:0]      span_count,
  output logic [15:0]      drop_count
);

  sched_state_t state_r;
  span_t        span_r;
  span_t        eng_r;
  span_t        span_in_s;
  span_t        norm_s;
  logic         cull_s;
  logic         pick_s;
  logic         hs_s;
  logic         last_grant_r;
  logic         grant_id_r;
  logic         eng_start_r;
  logic [15:0]  span_count_r;
  logic [15:0]  drop_count_r;

  // Round-robin choice: with both valid, favour the one not granted last.
  always_comb begin
    pick_s = 1'b0;
    if (req_valid == 2'b11) begin
      pick_s = ~last_grant_r;
    end else if (req_valid[0]) begin
      pick_s = 1'b0;
    end else begin
      pick_s = 1'b1;
    end
  end

  assign hs_s = (state_r == ST_IDLE) && (req_valid != 2'b00);

  // Ready goes only to the winner and only while idle.
  always_comb begin
    req_ready = 2'b00;
    if (hs_s) begin
      req_ready[pick_s] = 1'b1;
    end else begin
      req_ready = 2'b00;
    end
  end

  assign span_in_s = '{x0: req_x0[pick_s], x1: req_x1[pick_s], y: req_y[pick_s],
                       z1: req_z1[pick_s], z2: req_z2[pick_s]};

  span_normalize #(.SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)) u_norm (
    .span_in  (span_r),
    .span_out (norm_s),
    .cull     (cull_s)
  );

  // Scheduler FSM: latch, normalize, pulse start, then hold until engine done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      span_r       <= '0;
      eng_r        <= '0;
      last_grant_r <= 1'b1;
      grant_id_r   <= 1'b0;
      eng_start_r  <= 1'b0;
      span_count_r <= 16'd0;
      drop_count_r <= 16'd0;
    end else begin
      eng_start_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (hs_s) begin
            span_r       <= span_in_s;
            grant_id_r   <= pick_s;
            last_grant_r <= pick_s;
            state_r      <= ST_NORM;
          end
        end
        ST_NORM: begin
          if (cull_s) begin
            drop_count_r <= drop_count_r + 16'd1;
            state_r      <= ST_IDLE;
          end else begin
            eng_r       <= norm_s;
            eng_start_r <= 1'b1;
            state_r     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          span_count_r <= span_count_r + 16'd1;
          state_r      <= ST_WAIT;
        end
        ST_WAIT: begin
          if (eng_done) begin
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign eng_start  = eng_start_r;
  assign eng_x0     = eng_r.x0;
  assign eng_x1     = eng_r.x1;
  assign eng_y0     = eng_r.y;
  assign eng_y1     = eng_r.y;
  assign eng_z1     = eng_r.z1;
  assign eng_z2     = eng_r.z2;
  assign busy       = (state_r != ST_IDLE);
  assign grant_id   = grant_id_r;
  assign span_count = span_count_r;
  assign drop_count = drop_count_r;

endmodule
